// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory port: widths, FSM states and address checking.
package mips_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Misaligned, or any byte-address bit above the word-address field set.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous byte-enable word RAM with a registered read port; contents are never reset.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one outstanding load/store, fixed LATENCY, one-cycle response pulse.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic       LAT1     = (LATENCY == 32'd1);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 32'd1) ? (LATENCY - 32'd2) : 32'd0);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              err_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_load_q;

  logic              hs;
  logic              req_err;
  logic              enter_resp;
  logic              cur_we;
  logic              cur_err;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_be;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       arr_rdata;

  assign hs      = req_valid & ready_q;
  assign req_err = addr_err(req_addr, ADDR_W);

  // With LATENCY=1 the commit edge is the handshake edge itself, so the
  // memory must see the live request rather than the latched copy.
  assign enter_resp = ((state_q == IDLE) && hs && LAT1) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));

  always_comb begin
    cur_we    = we_q;
    cur_err   = err_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_err   = req_err;
      cur_addr  = req_addr[ADDR_W+1:2];
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
  end

  assign mem_we = enter_resp & cur_we & ~cur_err;
  assign mem_re = enter_resp & ~cur_we & ~cur_err;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (cur_be),
    .waddr_i (cur_addr),
    .wdata_i (cur_wdata),
    .re_i    (mem_re),
    .raddr_i (cur_addr),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= cur_err;
        rsp_load_q  <= ~cur_we & ~cur_err;
      end
      case (state_q)
        IDLE: begin
          if (hs) begin
            we_q    <= req_we;
            addr_q  <= req_addr[ADDR_W+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= req_err;
            ready_q <= 1'b0;
            cnt_q   <= CNT_INIT;
            state_q <= LAT1 ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  // Read data stays visible after the pulse; stores and errors show zero.
  assign rsp_rdata = rsp_load_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder at LATENCY 2, 3 and 1 against a word-array model.
module tb_dmem_responder;

  localparam int unsigned AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic [2:0]  req_valid, req_ready, rsp_valid, rsp_err;
  logic [31:0] rd0, rd1, rd2;

  int unsigned vectors = 0;
  int unsigned fails   = 0;

  logic [31:0] mdl   [3][1024];
  bit          known [3][1024];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rd0), .rsp_err(rsp_err[0]));

  dmem_responder #(.ADDR_W(AW), .LATENCY(3)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rd1), .rsp_err(rsp_err[1]));

  dmem_responder #(.ADDR_W(AW), .LATENCY(1)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rd2), .rsp_err(rsp_err[2]));

  function automatic int lat(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? rd0 : ((d == 1) ? rd1 : rd2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: bad address -> error, no effect; store merges enabled
  // bytes into the word; load returns the word as of all earlier stores.
  task automatic model_req(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output logic [31:0] exp_rd, output logic exp_err,
                           output bit check_data);
    int w;
    exp_err    = (addr % 4 != 0) || (addr >= (32'd4 << AW));
    exp_rd     = 32'd0;
    check_data = 1'b1;
    if (!exp_err) begin
      w = int'(addr / 4);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[d][w][8*i +: 8] = wdata[8*i +: 8];
        if (be == 4'hF) known[d][w] = 1'b1;
      end else if (known[d][w]) begin
        exp_rd = mdl[d][w];
      end else begin
        check_data = 1'b0;
      end
    end
  endtask

  task automatic transact(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          cd;
    int          k;
    model_req(d, we, addr, wdata, be, exp_rd, exp_err, cd);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid[d] = 1'b1;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready[d]) chk("ready_timeout", {31'd0, req_ready[d]}, 32'd1);
    @(negedge clk);
    req_valid[d] = 1'b0;
    k = 1;
    while (!rsp_valid[d] && k < 40) begin
      chk("busy_ready", {31'd0, req_ready[d]}, 32'd0);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(lat(d)));
    chk("rsp_ready", {31'd0, req_ready[d]}, 32'd0);
    chk("rsp_err", {31'd0, rsp_err[d]}, {31'd0, exp_err});
    if (cd) chk("rsp_rdata", rdata_of(d), exp_rd);
    @(negedge clk);
    chk("pulse_end", {31'd0, rsp_valid[d]}, 32'd0);
    chk("ready_back", {31'd0, req_ready[d]}, 32'd1);
    if (cd) chk("held_rdata", rdata_of(d), exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b_we   [4];
    logic [31:0] b_addr [4];
    logic [31:0] b_wd   [4];
    logic [3:0]  b_be   [4];
    logic [31:0] q_rd   [$];
    logic        q_err  [$];
    int          q_cyc  [$];
    int          hs_cyc [4];
    int          nhs, nrsp;
    bit          adv;
    logic [31:0] e_rd;
    logic        e_err;
    bit          e_cd;

    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 1024; w++) known[d][w] = 1'b0;

    rst = 1'b0;
    req_valid = '0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", {31'd0, req_ready[d]}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      chk("reset_rdata", rdata_of(d), 32'd0);
      chk("reset_err", {31'd0, rsp_err[d]}, 32'd0);
    end
    rst = 1'b1;

    // Full store, load back, partial store, empty store, error cases (LATENCY=2)
    transact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    transact(0, 1'b0, 32'h10, 32'h0, 4'h0);
    transact(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
    transact(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("partial_store_model", mdl[0][4], 32'hDEADBEAA);
    transact(0, 1'b1, 32'h10, 32'h12345678, 4'b0000);
    transact(0, 1'b0, 32'h10, 32'h0, 4'h0);
    transact(0, 1'b0, 32'h13, 32'h0, 4'h0);
    transact(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    transact(0, 1'b1, 32'h0000_1010, 32'hFFFFFFFF, 4'hF);
    transact(0, 1'b0, 32'h10, 32'h0, 4'h0);

    // Reset one cycle after accepting a store (LATENCY=3)
    transact(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11223344; req_be = 4'hF;
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, req_ready[1]}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    chk("midrst_rdata", rd1, 32'd0);
    chk("midrst_err", {31'd0, rsp_err[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    transact(1, 1'b0, 32'h20, 32'h0, 4'h0);

    // LATENCY=1 back-to-back with req_valid held high
    b_we[0] = 1'b1; b_addr[0] = 32'h40; b_wd[0] = $urandom; b_be[0] = 4'hF;
    b_we[1] = 1'b0; b_addr[1] = 32'h40; b_wd[1] = '0;       b_be[1] = 4'h0;
    b_we[2] = 1'b1; b_addr[2] = 32'h40; b_wd[2] = $urandom; b_be[2] = 4'b0110;
    b_we[3] = 1'b0; b_addr[3] = 32'h40; b_wd[3] = '0;       b_be[3] = 4'h0;
    nhs = 0; nrsp = 0; adv = 1'b0;
    @(negedge clk);
    req_we = b_we[0]; req_addr = b_addr[0]; req_wdata = b_wd[0]; req_be = b_be[0];
    req_valid[2] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (adv) begin
        adv = 1'b0;
        if (nhs < 4) begin
          req_we = b_we[nhs]; req_addr = b_addr[nhs]; req_wdata = b_wd[nhs]; req_be = b_be[nhs];
        end else begin
          req_valid[2] = 1'b0;
        end
      end
      if (rsp_valid[2]) begin
        if (q_rd.size() > 0) begin
          chk("b2b_rdata", rd2, q_rd.pop_front());
          chk("b2b_err", {31'd0, rsp_err[2]}, {31'd0, q_err.pop_front()});
          chk("b2b_lat", 32'(c), 32'(q_cyc.pop_front() + 1));
        end else begin
          chk("b2b_spurious", {31'd0, rsp_valid[2]}, 32'd0);
        end
        nrsp++;
      end
      if (req_ready[2] && req_valid[2]) begin
        if (nhs > 0) chk("b2b_spacing", 32'(c - hs_cyc[nhs-1]), 32'd2);
        hs_cyc[nhs] = c;
        model_req(2, b_we[nhs], b_addr[nhs], b_wd[nhs], b_be[nhs], e_rd, e_err, e_cd);
        q_rd.push_back(e_rd);
        q_err.push_back(e_err);
        q_cyc.push_back(c);
        nhs++;
        adv = 1'b1;
      end
    end
    chk("b2b_rsp_count", 32'(nrsp), 32'd4);
    chk("b2b_hs_count", 32'(nhs), 32'd4);

    // Randomized traffic on a small window, with misaligned and out-of-range mixed in
    for (int w = 0; w < 16; w++) transact(0, 1'b1, 32'(w * 4), $urandom, 4'hF);
    for (int n = 0; n < 60; n++) begin
      int unsigned sel, w;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      w   = $urandom_range(0, 15);
      if (sel < 7)       a = 32'(w * 4);
      else if (sel == 7) a = 32'(w * 4 + $urandom_range(1, 3));
      else               a = (32'($urandom_range(1, 1023)) << 12) | 32'(w * 4);
      transact(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
